awmc_actuator_driver: RTL and testbench

Downstream of the washing-machine controller FSM. Consumes the controller's `stage` code and `done` pulse and drives the physical actuators: water inlet valve, drain pump, drum motor (enable, direction, speed level), door lock and end-of-cycle buzzer. Adds timed agitation reversal, spin speed ramping and lock hold-off that the controller does not generate.

---
 rtl/awmc_actuator_driver.sv | 168 ++++++++++++++++
 tb/tb_awmc_actuator_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/awmc_actuator_driver.sv
// Actuator driver for the washing-machine controller. It turns stage/done into valve, pump,
// motor, lock and buzzer drive, and adds agitation reversal, spin ramping and a lock hold-off.
module awmc_actuator_driver #(
  parameter int AGITATE_TICKS = 4,
  parameter int DIR_DEAD      = 1,
  parameter int SPIN_MAX      = 7,
  parameter int RAMP_TICKS    = 2,
  parameter int LOCK_HOLD     = 2,
  parameter int BUZZ_TICKS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] stage,
  input  logic       done,
  output logic       water_valve,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic [2:0] spin_speed,
  output logic       door_lock,
  output logic       buzzer,
  output logic       fault
);

  typedef enum logic [1:0] {AG_OFF, AG_FWD, AG_GAP, AG_REV} ag_state_t;

  localparam logic [2:0] ST_FILL  = 3'b000;
  localparam logic [2:0] ST_WASH  = 3'b001;
  localparam logic [2:0] ST_RINSE = 3'b010;
  localparam logic [2:0] ST_SPIN  = 3'b011;
  localparam logic [2:0] ST_IDLE  = 3'b111;

  localparam int AGW = $clog2((AGITATE_TICKS > DIR_DEAD ? AGITATE_TICKS : DIR_DEAD) + 2);
  localparam int RW  = $clog2(RAMP_TICKS + 2);
  localparam int LW  = $clog2(LOCK_HOLD + 2);
  localparam int BW  = $clog2(BUZZ_TICKS + 2);

  localparam logic [AGW-1:0] AG_RUN_LAST = AGW'(AGITATE_TICKS - 1);
  localparam logic [AGW-1:0] AG_GAP_LAST = AGW'(DIR_DEAD - 1);
  localparam logic [RW-1:0]  RAMP_LAST   = RW'(RAMP_TICKS - 1);
  localparam logic [LW-1:0]  LOCK_INIT   = LW'(LOCK_HOLD);
  localparam logic [BW-1:0]  BUZZ_LAST   = BW'(BUZZ_TICKS - 1);
  localparam logic [2:0]     SPEED_MAX   = 3'(SPIN_MAX);

  ag_state_t      ag_state, ag_nx, ag_resume, ag_resume_nx;
  logic [AGW-1:0] ag_cnt, ag_cnt_nx;
  logic [RW-1:0]  ramp_cnt, ramp_cnt_nx;
  logic [LW-1:0]  lock_cnt;
  logic [BW-1:0]  buzz_cnt;
  logic [2:0]     prev_stage, speed_nx;
  logic           ramp_dir, done_q;

  logic illegal, st_fill, st_spin, agitate, idle_like, motor_en_nx, lock_cond;

  assign illegal   = (stage == 3'b101) || (stage == 3'b110);
  assign st_fill   = (stage == ST_FILL);
  assign st_spin   = (stage == ST_SPIN);
  assign agitate   = (stage == ST_WASH) || (stage == ST_RINSE);
  assign idle_like = (stage == ST_IDLE) || illegal;

  // Speed ramps up only in SPIN; a direction flip steps immediately.
  always_comb begin
    speed_nx    = spin_speed;
    ramp_cnt_nx = ramp_cnt - RW'(1);
    if ((st_spin != ramp_dir) || (ramp_cnt == '0)) begin
      ramp_cnt_nx = RAMP_LAST;
      if (st_spin && spin_speed < SPEED_MAX)
        speed_nx = spin_speed + 3'd1;
      else if (!st_spin && spin_speed != 3'd0)
        speed_nx = spin_speed - 3'd1;
    end
  end

  always_comb begin
    ag_nx        = ag_state;
    ag_cnt_nx    = ag_cnt + AGW'(1);
    ag_resume_nx = ag_resume;
    if (!agitate) begin
      ag_nx     = AG_OFF;
      ag_cnt_nx = '0;
    end else if ((stage != prev_stage) || (ag_state == AG_OFF)) begin
      // Agitation waits for the drum to coast to a stop.
      ag_nx     = (spin_speed == 3'd0) ? AG_FWD : AG_OFF;
      ag_cnt_nx = '0;
    end else begin
      case (ag_state)
        AG_FWD, AG_REV: begin
          if (ag_cnt == AG_RUN_LAST) begin
            ag_resume_nx = (ag_state == AG_FWD) ? AG_REV : AG_FWD;
            ag_nx        = (DIR_DEAD == 0) ? ag_resume_nx : AG_GAP;
            ag_cnt_nx    = '0;
          end
        end
        AG_GAP: begin
          if (ag_cnt == AG_GAP_LAST) begin
            ag_nx     = ag_resume;
            ag_cnt_nx = '0;
          end
        end
        default: begin
          ag_nx     = AG_OFF;
          ag_cnt_nx = '0;
        end
      endcase
    end
  end

  assign motor_en_nx = (ag_nx == AG_FWD) || (ag_nx == AG_REV) || (speed_nx != 3'd0);
  assign lock_cond   = !idle_like || motor_en_nx || (speed_nx != 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_stage  <= ST_IDLE;
      ramp_dir    <= 1'b0;
      ramp_cnt    <= '0;
      spin_speed  <= 3'd0;
      ag_state    <= AG_OFF;
      ag_resume   <= AG_REV;
      ag_cnt      <= '0;
      lock_cnt    <= '0;
      buzz_cnt    <= '0;
      done_q      <= 1'b0;
      water_valve <= 1'b0;
      drain_pump  <= 1'b0;
      motor_en    <= 1'b0;
      motor_dir   <= 1'b0;
      door_lock   <= 1'b0;
      buzzer      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      prev_stage  <= stage;
      ramp_dir    <= st_spin;
      ramp_cnt    <= ramp_cnt_nx;
      spin_speed  <= speed_nx;
      ag_state    <= ag_nx;
      ag_resume   <= ag_resume_nx;
      ag_cnt      <= ag_cnt_nx;
      water_valve <= st_fill;
      drain_pump  <= (stage == ST_RINSE) || st_spin;
      motor_en    <= motor_en_nx;
      motor_dir   <= (ag_nx == AG_REV);
      done_q      <= done;
      if (illegal) fault <= 1'b1;

      if (lock_cond) begin
        door_lock <= 1'b1;
        lock_cnt  <= LOCK_INIT;
      end else if (lock_cnt != '0) begin
        door_lock <= 1'b1;
        lock_cnt  <= lock_cnt - LW'(1);
      end else begin
        door_lock <= 1'b0;
      end

      // Only a rising edge of done (re)starts the beep.
      if (done && !done_q) begin
        buzzer   <= 1'b1;
        buzz_cnt <= BUZZ_LAST;
      end else if (buzz_cnt != '0) begin
        buzzer   <= 1'b1;
        buzz_cnt <= buzz_cnt - BW'(1);
      end else begin
        buzzer   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_awmc_actuator_driver.sv
// Directed bench for awmc_actuator_driver: one task per scenario, hand-computed expectations.
module tb_awmc_actuator_driver;

  localparam logic [2:0] FILL = 3'b000, WASH = 3'b001, RINSE = 3'b010, SPIN = 3'b011,
                         STOP = 3'b100, IDLE = 3'b111;

  logic       clk = 1'b0, reset = 1'b1, done = 1'b0;
  logic [2:0] stage = IDLE;
  logic       water_valve, drain_pump, motor_en, motor_dir, door_lock, buzzer, fault;
  logic [2:0] spin_speed;
  int total = 0, bad = 0;

  awmc_actuator_driver dut (
    .clk(clk), .reset(reset), .stage(stage), .done(done),
    .water_valve(water_valve), .drain_pump(drain_pump), .motor_en(motor_en),
    .motor_dir(motor_dir), .spin_speed(spin_speed), .door_lock(door_lock),
    .buzzer(buzzer), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({water_valve, drain_pump, motor_en, motor_dir, spin_speed, door_lock, buzzer, fault} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", {water_valve, drain_pump, motor_en, motor_dir, spin_speed, door_lock, buzzer, fault});
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_fill();
    stage = FILL;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if ({water_valve, drain_pump, door_lock} !== 3'b101) begin
        bad++; $display("FAIL fill_step%0d: valve/pump/lock=%b want 101", k, {water_valve, drain_pump, door_lock});
      end
    end
    stage = IDLE;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if ({water_valve, door_lock} !== {1'b0, (k < 3)}) begin
        bad++; $display("FAIL fill_idle%0d: valve/lock=%b want %b", k, {water_valve, door_lock}, {1'b0, (k < 3)});
      end
    end
  endtask

  task automatic test_wash();
    logic [11:0] en_exp, dir_exp;
    en_exp  = 12'b1111_0111_1011;
    dir_exp = 12'b0000_0111_1000;
    stage = WASH;
    for (int k = 1; k <= 12; k++) begin
      step();
      total++;
      if ({motor_en, motor_dir, drain_pump, water_valve} !== {en_exp[12-k], dir_exp[12-k], 2'b00}) begin
        bad++;
        $display("FAIL wash_step%0d: en/dir/pump/valve=%b want %b", k,
                 {motor_en, motor_dir, drain_pump, water_valve}, {en_exp[12-k], dir_exp[12-k], 2'b00});
      end
    end
    stage = IDLE;
    step();
    total++;
    if (motor_en !== 1'b0) begin
      bad++; $display("FAIL wash_exit: motor_en=%b want 0", motor_en);
    end
    step(); step();
  endtask

  task automatic test_spin();
    logic [2:0] exp;
    stage = SPIN;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = (k >= 13) ? 3'd7 : 3'((k + 1) / 2);
      total++;
      if ({spin_speed, drain_pump, motor_en, motor_dir} !== {exp, 3'b110}) begin
        bad++; $display("FAIL spin_up%0d: speed=%0d pump/en/dir=%b want %0d 110", k,
                        spin_speed, {drain_pump, motor_en, motor_dir}, exp);
      end
    end
    stage = STOP;
    for (int k = 1; k <= 13; k++) begin
      step();
      exp = 3'(7 - (k + 1) / 2);
      total++;
      if ({spin_speed, drain_pump, motor_en, door_lock} !== {exp, 1'b0, (k < 13), 1'b1}) begin
        bad++; $display("FAIL spin_stop%0d: speed=%0d pump/en/lock=%b want %0d 0%b1", k,
                        spin_speed, {drain_pump, motor_en, door_lock}, exp, (k < 13));
      end
    end
    stage = IDLE;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (door_lock !== (k < 3)) begin
        bad++; $display("FAIL spin_lock%0d: lock=%b want %b", k, door_lock, (k < 3));
      end
    end
  endtask

  task automatic test_pause();
    logic [2:0] pause_exp [4];
    logic [2:0] resume_exp [7];
    logic [2:0] wash_spd [7];
    logic [6:0] wash_en;
    pause_exp  = '{3'd4, 3'd4, 3'd3, 3'd3};
    resume_exp = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7};
    wash_spd   = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
    wash_en    = 7'b1111101;
    stage = SPIN;
    for (int k = 1; k <= 9; k++) step();
    total++;
    if (spin_speed !== 3'd5) begin
      bad++; $display("FAIL pause_pre: speed=%0d want 5", spin_speed);
    end
    stage = IDLE;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({spin_speed, door_lock} !== {pause_exp[k], 1'b1}) begin
        bad++; $display("FAIL pause_down%0d: speed=%0d lock=%b want %0d 1", k, spin_speed, door_lock, pause_exp[k]);
      end
    end
    stage = SPIN;
    for (int k = 0; k < 7; k++) begin
      step();
      total++;
      if ({spin_speed, door_lock} !== {resume_exp[k], 1'b1}) begin
        bad++; $display("FAIL pause_resume%0d: speed=%0d lock=%b want %0d 1", k, spin_speed, door_lock, resume_exp[k]);
      end
    end
    stage = STOP;
    for (int k = 1; k <= 7; k++) step();
    total++;
    if (spin_speed !== 3'd3) begin
      bad++; $display("FAIL pause_stop: speed=%0d want 3", spin_speed);
    end
    stage = WASH;
    for (int k = 0; k < 7; k++) begin
      step();
      total++;
      if ({spin_speed, motor_en, motor_dir} !== {wash_spd[k], wash_en[6-k], 1'b0}) begin
        bad++; $display("FAIL wash_wait%0d: speed=%0d en/dir=%b want %0d %b0", k,
                        spin_speed, {motor_en, motor_dir}, wash_spd[k], wash_en[6-k]);
      end
    end
    stage = IDLE;
    for (int k = 1; k <= 3; k++) step();
    total++;
    if (door_lock !== 1'b0) begin
      bad++; $display("FAIL pause_unlock: lock=%b want 0", door_lock);
    end
  endtask

  task automatic test_buzzer();
    logic [4:0] exp_a;
    logic [5:0] drv_b, exp_b;
    exp_a = 5'b11100;
    done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (buzzer !== exp_a[4-k]) begin
        bad++; $display("FAIL buzz_level%0d: buzzer=%b want %b", k, buzzer, exp_a[4-k]);
      end
    end
    done = 1'b0;
    step();
    drv_b = 6'b101111;
    exp_b = 6'b111110;
    for (int k = 0; k < 6; k++) begin
      done = drv_b[5-k];
      step();
      total++;
      if (buzzer !== exp_b[5-k]) begin
        bad++; $display("FAIL buzz_retrig%0d: buzzer=%b want %b", k, buzzer, exp_b[5-k]);
      end
    end
    done = 1'b0;
    step();
  endtask

  task automatic test_fault();
    stage = 3'b101;
    step();
    total++;
    if ({fault, water_valve, drain_pump, motor_en, door_lock} !== 5'b10000) begin
      bad++; $display("FAIL fault_set: fault/valve/pump/en/lock=%b want 10000",
                      {fault, water_valve, drain_pump, motor_en, door_lock});
    end
    stage = IDLE;
    step();
    total++;
    if (fault !== 1'b1) begin
      bad++; $display("FAIL fault_sticky: fault=%b want 1", fault);
    end
    stage = 3'b110;
    step();
    total++;
    if ({fault, drain_pump} !== 2'b10) begin
      bad++; $display("FAIL fault_110: fault/pump=%b want 10", {fault, drain_pump});
    end
    stage = IDLE;
    reset = 1'b1;
    #1;
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL fault_clear: fault=%b want 0", fault);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    stage = SPIN;
    for (int k = 1; k <= 9; k++) step();
    total++;
    if (spin_speed !== 3'd5) begin
      bad++; $display("FAIL areset_pre: speed=%0d want 5", spin_speed);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({water_valve, drain_pump, motor_en, motor_dir, spin_speed, door_lock, buzzer, fault} !== 10'b0) begin
      bad++; $display("FAIL areset_async: got %b want 0",
                      {water_valve, drain_pump, motor_en, motor_dir, spin_speed, door_lock, buzzer, fault});
    end
    stage = IDLE;
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wash();
    test_spin();
    test_pause();
    test_buzzer();
    test_fault();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
